// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry {pc, instr} FIFO with branch-flush
// that retains the delay slot. Latency 1 cycle (no bypass); in_ready gates the PC register.
module fetch_queue #(
    parameter int          DEPTH = 4,
    parameter int          PTR_W = 2,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    input  logic             out_ready,
    input  logic             flush,
    output logic             slot_pend,
    output logic [PTR_W:0]   count
);

    localparam logic [31:0]    RESET_PC = 32'h0000_3000;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_TWO = PTR_W'(2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    logic [31:0]      pc_mem  [DEPTH];
    logic [31:0]      ins_mem [DEPTH];

    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [0:0]       state_q, state_d;

    logic push, pop, do_flush, has_behind, wr_en;

    assign out_valid  = (cnt_q != '0);
    assign pop        = out_valid & out_ready;
    assign in_ready   = (cnt_q < FULL_CNT) | pop;
    assign push       = in_valid & in_ready;
    assign do_flush   = flush & pop;
    assign has_behind = (cnt_q > CNT_ONE);

    assign out_pc    = out_valid ? pc_mem[rd_q]  : RESET_PC;
    assign out_instr = out_valid ? ins_mem[rd_q] : NOP;
    assign slot_pend = (state_q == ST_PEND);
    assign count     = cnt_q;

    always_comb begin
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        wr_en   = 1'b0;
        if (do_flush) begin
            // Only one entry survives: the delay slot, taken from the queue first, else from fetch.
            rd_d = rd_q + PTR_ONE;
            if (has_behind) begin
                wr_d  = rd_q + PTR_TWO;
                cnt_d = CNT_ONE;
            end else if (push) begin
                wr_en = 1'b1;
                wr_d  = wr_q + PTR_ONE;
                cnt_d = CNT_ONE;
            end else begin
                cnt_d   = '0;
                state_d = ST_PEND;
            end
        end else begin
            if (push) begin
                wr_en   = 1'b1;
                wr_d    = wr_q + PTR_ONE;
                state_d = ST_IDLE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_ONE;
                2'b01:   cnt_d = cnt_q - CNT_ONE;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Storage needs no reset; validity is tracked by the count alone.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_q]  <= in_pc;
            ins_mem[wr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized + directed bench for fetch_queue with a queue-based reference model and pop monitor.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready, flush;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid, slot_pend;
    logic [31:0] out_pc, out_instr;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr), .out_ready(out_ready),
        .flush(flush), .slot_pend(slot_pend), .count(count)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [63:0] sb[$];
    logic [63:0] mon_e;
    logic [63:0] keep_e;
    bit          pend;
    logic [31:0] fetch_pc;
    bit          m_push, m_pop, m_flush, m_rdy;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every DUT pop must match the oldest entry the model holds.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got pc %h expected no pop at %0t", out_pc, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("pop_pc", out_pc, mon_e[63:32]);
                chk("pop_instr", out_instr, mon_e[31:0]);
            end
        end
    end

    // Called just after a rising edge; drives one cycle and updates the model at the next edge.
    task automatic cycle(input bit v, input bit ordy, input bit fl);
        in_valid  = v;
        in_pc     = fetch_pc;
        in_instr  = $urandom;
        out_ready = ordy;
        flush     = fl;
        m_cnt   = sb.size();
        m_pop   = (m_cnt > 0) && ordy;
        m_rdy   = (m_cnt < 4) || m_pop;
        m_push  = v && m_rdy;
        m_flush = fl && m_pop;
        @(negedge clk);
        chk("in_ready", in_ready, m_rdy);
        chk("out_valid", out_valid, m_cnt > 0);
        chk("count", count, m_cnt);
        chk("slot_pend", slot_pend, pend);
        if (m_cnt == 0) chk("empty_instr", out_instr, 32'h0);
        @(posedge clk);
        if (m_flush) begin
            if (sb.size() > 0) begin
                keep_e = sb[0];
                sb.delete();
                sb.push_back(keep_e);
            end else if (m_push) begin
                sb.push_back({in_pc, in_instr});
            end else begin
                pend = 1'b1;
            end
        end else if (m_push) begin
            sb.push_back({in_pc, in_instr});
            pend = 1'b0;
        end
        if (m_push) fetch_pc = fetch_pc + 32'd4;
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        sb.delete();
        pend     = 1'b0;
        fetch_pc = 32'h0000_3000;
        #1;
        reset = 1'b1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pc", out_pc, 32'h0000_3000);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", count, 3'd0);
        chk("rst_slot_pend", slot_pend, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc = '0; in_instr = '0; fetch_pc = 32'h0000_3000; pend = 1'b0;
        @(posedge clk);
        #1;

        // Fill three, then the fourth, then a held fifth accepted alongside a pop.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        chk("t1_count", count, 3'd3);
        chk("t1_out_pc", out_pc, 32'h0000_3000);
        chk("t1_in_ready", in_ready, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        chk("t2_count", count, 3'd4);
        chk("t2_in_ready", in_ready, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("t2_held_pc", fetch_pc, 32'h0000_3010);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t2_count_after", count, 3'd4);
        drain();

        // Flush with an entry behind the head: only 3004 survives.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("t3_count", count, 3'd1);
        chk("t3_out_pc", out_pc, 32'h0000_3004);
        cycle(1'b0, 1'b1, 1'b0);
        chk("t3_empty", count, 3'd0);

        // Flush with the delay slot arriving in the same cycle.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("t4_count", count, 3'd1);
        chk("t4_out_pc", out_pc, 32'h0000_3004);
        chk("t4_slot_pend", slot_pend, 1'b0);
        drain();

        // Flush with no delay slot yet: pending until the next push.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("t5_slot_pend", slot_pend, 1'b1);
        chk("t5_count", count, 3'd0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("t5_count_after", count, 3'd1);
        chk("t5_pend_after", slot_pend, 1'b0);
        chk("t5_out_pc", out_pc, 32'h0000_3004);
        drain();

        // Reset while pending clears it.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        chk("t5b_pend", slot_pend, 1'b1);
        do_reset();

        // Random stream with wraparound, flushes and a mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            else cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
